// File: rtl/sdram_sched_pkg.sv
`default_nettype none
// ============================================================================
// sdram_sched_pkg : state and grant encodings shared by the burst scheduler
// Revision 1.0
// ============================================================================
package sdram_sched_pkg;

  // One-hot, matching the arbiter's state style
  localparam logic [2:0] S_IDLE    = 3'b001;
  localparam logic [2:0] S_WR_BUSY = 3'b010;
  localparam logic [2:0] S_RD_BUSY = 3'b100;

  localparam logic SERVED_WRITE = 1'b1;
  localparam logic SERVED_READ  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/sdram_bank_tracker.sv
`default_nettype none
// ============================================================================
// sdram_bank_tracker : ping-pong bank bit plus burst index within the bank
// Revision 1.0
// ============================================================================
module sdram_bank_tracker #(
  parameter int BURSTS_PER_BANK = 16,
  parameter int IDX_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic             bank,
  output logic [IDX_W-1:0] burst_idx,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURSTS_PER_BANK - 1);

  // Combinational so the owner can update bank flags on the same edge
  assign wrap = advance && (burst_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank      <= 1'b0;
      burst_idx <= '0;
    end else if (wrap) begin
      bank      <= ~bank;
      burst_idx <= '0;
    end else if (advance) begin
      burst_idx <= burst_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_rw_sched.sv
`default_nettype none
// ============================================================================
// sdram_rw_sched : one-at-a-time write/read burst trigger scheduler with
//                  ping-pong bank ownership between writer and reader
// Revision 1.0
// ============================================================================
module sdram_rw_sched
  import sdram_sched_pkg::*;
#(
  parameter int BURST_LEN       = 256,
  parameter int FIFO_AW         = 10,
  parameter int BURSTS_PER_BANK = 16,
  localparam int IDX_W = (BURSTS_PER_BANK > 1) ? $clog2(BURSTS_PER_BANK) : 1
) (
  input  logic             sysclk_100M,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [FIFO_AW:0] wfifo_level,
  input  logic [FIFO_AW:0] rfifo_level,
  input  logic             wr_done,
  input  logic             rd_done,
  output logic             write_trig,
  output logic             read_trig,
  output logic [1:0]       wr_bank,
  output logic [1:0]       rd_bank,
  output logic [IDX_W-1:0] wr_burst_idx,
  output logic [IDX_W-1:0] rd_burst_idx,
  output logic             wr_stall,
  output logic             proto_err
);

  localparam logic [FIFO_AW:0] DEPTH_LVL  = (FIFO_AW+1)'(2**FIFO_AW);
  localparam logic [FIFO_AW:0] BURST_LVL  = (FIFO_AW+1)'(BURST_LEN);
  // Read FIFO has room for a burst when its level is at most this
  localparam logic [FIFO_AW:0] RD_MAX_LVL = DEPTH_LVL - BURST_LVL;

  logic [2:0] state;
  logic       last_served;
  logic [1:0] bank_full;
  logic       wr_bank_b, rd_bank_b;
  logic       wr_adv, rd_adv, wr_wrap, rd_wrap;
  logic       wr_elig, rd_elig, grant_wr, grant_rd, bad_done;

  assign wr_elig  = enable && (wfifo_level >= BURST_LVL) && !bank_full[wr_bank_b];
  assign rd_elig  = enable && bank_full[rd_bank_b] && (rfifo_level <= RD_MAX_LVL);
  assign grant_wr = (state == S_IDLE) && wr_elig && (!rd_elig || last_served == SERVED_READ);
  assign grant_rd = (state == S_IDLE) && rd_elig && (!wr_elig || last_served == SERVED_WRITE);

  assign wr_adv   = (state == S_WR_BUSY) && wr_done;
  assign rd_adv   = (state == S_RD_BUSY) && rd_done;
  assign bad_done = ((state == S_IDLE)    && (wr_done || rd_done)) ||
                    ((state == S_WR_BUSY) && rd_done) ||
                    ((state == S_RD_BUSY) && wr_done);

  assign wr_bank  = {1'b0, wr_bank_b};
  assign rd_bank  = {1'b0, rd_bank_b};

  sdram_bank_tracker #(
    .BURSTS_PER_BANK (BURSTS_PER_BANK),
    .IDX_W           (IDX_W)
  ) u_wr_trk (
    .clk       (sysclk_100M),
    .rst_n     (rst_n),
    .advance   (wr_adv),
    .bank      (wr_bank_b),
    .burst_idx (wr_burst_idx),
    .wrap      (wr_wrap)
  );

  sdram_bank_tracker #(
    .BURSTS_PER_BANK (BURSTS_PER_BANK),
    .IDX_W           (IDX_W)
  ) u_rd_trk (
    .clk       (sysclk_100M),
    .rst_n     (rst_n),
    .advance   (rd_adv),
    .bank      (rd_bank_b),
    .burst_idx (rd_burst_idx),
    .wrap      (rd_wrap)
  );

  always_ff @(posedge sysclk_100M) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      write_trig  <= 1'b0;
      read_trig   <= 1'b0;
      last_served <= SERVED_READ;
      bank_full   <= 2'b00;
      wr_stall    <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      write_trig <= grant_wr;
      read_trig  <= grant_rd;
      if (wfifo_level == DEPTH_LVL) wr_stall  <= 1'b1;
      if (bad_done)                 proto_err <= 1'b1;
      if (wr_wrap) bank_full[wr_bank_b] <= 1'b1;
      if (rd_wrap) bank_full[rd_bank_b] <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_wr) begin
            state       <= S_WR_BUSY;
            last_served <= SERVED_WRITE;
          end else if (grant_rd) begin
            state       <= S_RD_BUSY;
            last_served <= SERVED_READ;
          end
        end
        S_WR_BUSY: if (wr_done) state <= S_IDLE;
        S_RD_BUSY: if (rd_done) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_rw_sched.sv
`default_nettype none
// ============================================================================
// tb_sdram_rw_sched : scoreboard bench for the burst scheduler
// Revision 1.0
// ============================================================================
module tb_sdram_rw_sched;

  logic        clk = 1'b0;
  logic        rst_n, enable, wr_done, rd_done;
  logic [10:0] wfifo_level, rfifo_level;
  logic        write_trig, read_trig, wr_stall, proto_err;
  logic [1:0]  wr_bank, rd_bank;
  logic [3:0]  wr_burst_idx, rd_burst_idx;

  typedef struct packed {
    logic       wr;
    logic [1:0] bank;
    logic [3:0] idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   m_wb, m_wi, m_rb, m_ri;

  always #5 clk = ~clk;

  sdram_rw_sched dut (
    .sysclk_100M  (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .wfifo_level  (wfifo_level),
    .rfifo_level  (rfifo_level),
    .wr_done      (wr_done),
    .rd_done      (rd_done),
    .write_trig   (write_trig),
    .read_trig    (read_trig),
    .wr_bank      (wr_bank),
    .rd_bank      (rd_bank),
    .wr_burst_idx (wr_burst_idx),
    .rd_burst_idx (rd_burst_idx),
    .wr_stall     (wr_stall),
    .proto_err    (proto_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a trigger appears
  initial begin
    exp_t e;
    bit   prev = 1'b0;
    int   a_bank, a_idx;
    forever begin
      @(negedge clk);
      if (write_trig || read_trig) begin
        chk("trig_overlap", int'(write_trig && read_trig), 0);
        chk("trig_back_to_back", int'(prev), 0);
        a_bank = write_trig ? int'(wr_bank) : int'(rd_bank);
        a_idx  = write_trig ? int'(wr_burst_idx) : int'(rd_burst_idx);
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_trig: got wr=%0d bank=%0d idx=%0d expected none",
                   write_trig, a_bank, a_idx);
        end else begin
          e = q.pop_front();
          if (e.wr !== write_trig || int'(e.bank) != a_bank || int'(e.idx) != a_idx) begin
            failures++;
            $display("FAIL trig_grant: got wr=%0d bank=%0d idx=%0d expected wr=%0d bank=%0d idx=%0d",
                     write_trig, a_bank, a_idx, e.wr, e.bank, e.idx);
          end
        end
      end
      prev = write_trig || read_trig;
    end
  end

  task automatic wait_trig(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (write_trig || read_trig) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Expect one burst of the given kind, answer it with a done after d cycles
  task automatic burst(input bit is_wr, input int d, input bit drop_en);
    bit ok;
    exp_t e;
    e.wr   = is_wr;
    e.bank = is_wr ? 2'(m_wb) : 2'(m_rb);
    e.idx  = is_wr ? 4'(m_wi) : 4'(m_ri);
    q.push_back(e);
    wait_trig(ok);
    chk("trig_timeout", int'(ok), 1);
    if (!ok) return;
    if (drop_en) enable = 1'b0;
    repeat (d) begin @(posedge clk); #1; end
    if (is_wr) wr_done = 1'b1; else rd_done = 1'b1;
    @(posedge clk); #1;
    wr_done = 1'b0;
    rd_done = 1'b0;
    if (is_wr) begin
      if (m_wi == 15) begin m_wi = 0; m_wb ^= 1; end else m_wi++;
      chk("wr_idx_after_done", int'(wr_burst_idx), m_wi);
      chk("wr_bank_after_done", int'(wr_bank), m_wb);
    end else begin
      if (m_ri == 15) begin m_ri = 0; m_rb ^= 1; end else m_ri++;
      chk("rd_idx_after_done", int'(rd_burst_idx), m_ri);
      chk("rd_bank_after_done", int'(rd_bank), m_rb);
    end
    chk("gap_after_done", int'(write_trig || read_trig), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_write_trig"}, int'(write_trig), 0);
    chk({tag, "_read_trig"}, int'(read_trig), 0);
    chk({tag, "_wr_bank"}, int'(wr_bank), 0);
    chk({tag, "_rd_bank"}, int'(rd_bank), 0);
    chk({tag, "_wr_idx"}, int'(wr_burst_idx), 0);
    chk({tag, "_rd_idx"}, int'(rd_burst_idx), 0);
    chk({tag, "_wr_stall"}, int'(wr_stall), 0);
    chk({tag, "_proto_err"}, int'(proto_err), 0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; enable = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
    wfifo_level = '0; rfifo_level = 11'd1024;
    m_wb = 0; m_wi = 0; m_rb = 0; m_ri = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    enable = 1'b1;

    // Fill both banks; reader has no room, so only writes are granted
    wfifo_level = 11'd256;
    for (int i = 0; i < 32; i++) burst(1'b1, i % 3, 1'b0);
    chk("wr_bank_wrapped_home", int'(wr_bank), 0);
    chk("wr_stall_not_yet", int'(wr_stall), 0);

    // Both banks full: writer blocked even with a full write FIFO
    wfifo_level = 11'd1024;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (write_trig || read_trig) seen = 1'b1;
    end
    chk("blocked_no_trig", int'(seen), 0);
    chk("wr_stall_set", int'(wr_stall), 1);

    // Reader drains bank 0; writer stays blocked until the last read
    rfifo_level = 11'd0;
    for (int i = 0; i < 16; i++) burst(1'b0, (i + 1) % 2, 1'b0);
    chk("rd_bank_handover", int'(rd_bank), 1);

    // Contention: last grant was a read, so write first, then alternate
    burst(1'b1, 0, 1'b0);
    burst(1'b0, 1, 1'b0);
    burst(1'b1, 2, 1'b0);
    burst(1'b0, 1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (write_trig || read_trig) seen = 1'b1;
    end
    chk("disabled_no_trig", int'(seen), 0);
    chk("proto_err_clean", int'(proto_err), 0);

    // Stray rd_done in idle
    rd_done = 1'b1;
    @(posedge clk); #1;
    rd_done = 1'b0;
    chk("proto_err_set", int'(proto_err), 1);
    chk("stray_rd_idx", int'(rd_burst_idx), m_ri);
    chk("stray_rd_bank", int'(rd_bank), m_rb);
    chk("stray_wr_idx", int'(wr_burst_idx), m_wi);

    // Reset mid-burst, then a late wr_done
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_wb = 0; m_wi = 0; m_rb = 0; m_ri = 0;
    enable = 1'b1; wfifo_level = 11'd256; rfifo_level = 11'd1024;
    begin
      exp_t e;
      bit ok;
      e.wr = 1'b1; e.bank = 2'd0; e.idx = 4'd0;
      q.push_back(e);
      wait_trig(ok);
      chk("mid_trig_timeout", int'(ok), 1);
    end
    enable = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("mid_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    wr_done = 1'b1;
    @(posedge clk); #1;
    wr_done = 1'b0;
    chk("late_done_proto_err", int'(proto_err), 1);
    chk("late_done_wr_idx", int'(wr_burst_idx), 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
